// File: rtl/spi_ram.sv
// Byte-wide command-driven RAM behind an SPI slave: 10-bit words carry a 2-bit
// opcode (set write addr, write data, set read addr, read data) plus an 8-bit payload.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [9:0] din,
    output logic       tx_valid,
    output logic [7:0] dout
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    logic [7:0]           mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    cmd_t cmd;
    logic wr_addr_en;
    logic wr_data_en;
    logic rd_addr_en;
    logic rd_data_en;

    assign cmd = cmd_t'(din[9:8]);

    always_comb begin
        wr_addr_en = 1'b0;
        wr_data_en = 1'b0;
        rd_addr_en = 1'b0;
        rd_data_en = 1'b0;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_en = 1'b1;
                CMD_WR_DATA: wr_data_en = 1'b1;
                CMD_RD_ADDR: rd_addr_en = 1'b1;
                CMD_RD_DATA: rd_data_en = 1'b1;
                default: ;
            endcase
        end
    end

    // Array has no reset so contents survive rst_n and map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_data_en) begin
            mem[wr_addr] <= din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else begin
            if (wr_addr_en) begin
                wr_addr <= din[ADDR_SIZE-1:0];
            end
            if (rd_addr_en) begin
                rd_addr <= din[ADDR_SIZE-1:0];
            end
        end
    end

    // Registered read port; dout holds between reads, tx_valid is a one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= rd_data_en;
            if (rd_data_en) begin
                dout <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// Directed self-checking bench for spi_ram: one task per scenario, inline checks.
module tb_spi_ram;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [9:0] din;
    logic       tx_valid;
    logic [7:0] dout;

    int errors = 0;
    int checks = 0;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .din      (din),
        .tx_valid (tx_valid),
        .dout     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one word at the falling edge, return 1ns after the capturing rising edge.
    task automatic send(input logic [9:0] word);
        @(negedge clk);
        rx_valid = 1'b1;
        din      = word;
        @(posedge clk);
        #1;
        $display("send din=%03h -> tx_valid=%0b dout=%02h", word, tx_valid, dout);
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
        din      = 10'h000;
        @(posedge clk);
        #1;
        $display("idle -> tx_valid=%0b dout=%02h", tx_valid, dout);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout actual=%02h required=00", dout);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_valid actual=%0b required=0", tx_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // No address set yet: write lands at 0, read fetches 0.
        send(10'h155);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_tx_valid actual=%0b required=0", tx_valid);
        end
        send(10'h300);
        checks++;
        if (tx_valid !== 1'b1 || dout !== 8'h55) begin
            errors++;
            $display("FAIL reset_rd_addr0 actual=%0b/%02h required=1/55", tx_valid, dout);
        end
    endtask

    task automatic test_round_trip();
        send(10'h001);
        send(10'h10D);
        send(10'h201);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rt_pre_tx_valid actual=%0b required=0", tx_valid);
        end
        send(10'h301);
        checks++;
        if (tx_valid !== 1'b1 || dout !== 8'h0D) begin
            errors++;
            $display("FAIL round_trip actual=%0b/%02h required=1/0D", tx_valid, dout);
        end
    endtask

    task automatic test_independence();
        send(10'h009);
        send(10'h10F);
        send(10'h209);
        send(10'h309);
        checks++;
        if (dout !== 8'h0F) begin
            errors++;
            $display("FAIL indep_addr9 actual=%02h required=0F", dout);
        end
        send(10'h001);
        send(10'h16D);
        send(10'h201);
        send(10'h301);
        checks++;
        if (dout !== 8'h6D) begin
            errors++;
            $display("FAIL indep_addr1 actual=%02h required=6D", dout);
        end
        send(10'h209);
        send(10'h003);
        send(10'h1AA);
        send(10'h309);
        checks++;
        if (dout !== 8'h0F) begin
            errors++;
            $display("FAIL indep_rd_kept actual=%02h required=0F", dout);
        end
        send(10'h203);
        send(10'h300);
        checks++;
        if (dout !== 8'hAA) begin
            errors++;
            $display("FAIL indep_addr3 actual=%02h required=AA", dout);
        end
    endtask

    task automatic test_hold_strobe();
        idle();
        checks++;
        if (tx_valid !== 1'b0 || dout !== 8'hAA) begin
            errors++;
            $display("FAIL hold actual=%0b/%02h required=0/AA", tx_valid, dout);
        end
        send(10'h3FF);
        checks++;
        if (tx_valid !== 1'b1 || dout !== 8'hAA) begin
            errors++;
            $display("FAIL b2b_first actual=%0b/%02h required=1/AA", tx_valid, dout);
        end
        send(10'h3FF);
        checks++;
        if (tx_valid !== 1'b1 || dout !== 8'hAA) begin
            errors++;
            $display("FAIL b2b_second actual=%0b/%02h required=1/AA", tx_valid, dout);
        end
        idle();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end actual=%0b required=0", tx_valid);
        end
    endtask

    task automatic test_boundary();
        send(10'h000);
        send(10'h1A5);
        send(10'h0FF);
        send(10'h15A);
        send(10'h200);
        send(10'h300);
        checks++;
        if (dout !== 8'hA5) begin
            errors++;
            $display("FAIL boundary_00 actual=%02h required=A5", dout);
        end
        send(10'h2FF);
        send(10'h300);
        checks++;
        if (dout !== 8'h5A) begin
            errors++;
            $display("FAIL boundary_ff actual=%02h required=5A", dout);
        end
        // Write on one cycle, read the same address on the next.
        send(10'h204);
        send(10'h004);
        send(10'h1E1);
        send(10'h300);
        checks++;
        if (dout !== 8'hE1) begin
            errors++;
            $display("FAIL wr_then_rd actual=%02h required=E1", dout);
        end
    endtask

    task automatic test_async_reset();
        send(10'h2FF);
        send(10'h300);
        checks++;
        if (tx_valid !== 1'b1 || dout !== 8'h5A) begin
            errors++;
            $display("FAIL pre_reset_rd actual=%0b/%02h required=1/5A", tx_valid, dout);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL async_reset actual=%0b/%02h required=0/00", tx_valid, dout);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(10'h300);
        checks++;
        if (dout !== 8'hA5) begin
            errors++;
            $display("FAIL post_reset_rd0 actual=%02h required=A5", dout);
        end
        send(10'h2FF);
        send(10'h300);
        checks++;
        if (dout !== 8'h5A) begin
            errors++;
            $display("FAIL post_reset_rdff actual=%02h required=5A", dout);
        end
        send(10'h177);
        send(10'h200);
        send(10'h300);
        checks++;
        if (dout !== 8'h77) begin
            errors++;
            $display("FAIL post_reset_wr0 actual=%02h required=77", dout);
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_independence();
        test_hold_strobe();
        test_boundary();
        test_async_reset();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
